mdio_receiver: RTL and testbench

//  Downstream partner of the MDIO management generator: the PHY-side slave that consumes mdc/mdio_out/mdio_oe.

---
 rtl/mdio_receiver.sv | 170 +++++++++++++++++
 tb/tb_mdio_receiver.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mdio_receiver.sv
// MDIO clause-22 slave: decodes frames clocked by mdc, issues register-file
// writes, and serialises register read data back onto mdio_in.
module mdio_receiver #(
  parameter logic [4:0] PHY_ADDR = 5'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mdc,
  input  logic        mdio_oe,
  input  logic        mdio_out,
  input  logic [15:0] reg_rdata,
  output logic        mdio_in,
  output logic [4:0]  reg_addr,
  output logic [15:0] reg_wdata,
  output logic        reg_we,
  output logic        rd_done,
  output logic        frame_err,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    WR,
    RD_TA,
    RD_DATA,
    DRAIN
  } state_t;

  state_t      state, state_next;
  logic        mdc_q;
  logic        rise;
  logic [5:0]  cnt, cnt_next;
  logic [13:0] hdr, hdr_next;
  logic [17:0] wr_sh, wr_sh_next;
  logic [14:0] rd_sh, rd_sh_next;
  logic        mdio_in_next;
  logic [4:0]  reg_addr_next;
  logic [15:0] reg_wdata_next;
  logic        reg_we_next;
  logic        rd_done_next;
  logic        frame_err_next;

  // rise marks the single clk cycle in which an mdc rising edge is acted on
  assign rise = mdc & ~mdc_q;
  assign busy = (state != IDLE);

  // Register the mdc history, FSM state, datapath and the one-clk strobes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mdc_q     <= 1'b0;
      state     <= IDLE;
      cnt       <= 6'd0;
      hdr       <= 14'd0;
      wr_sh     <= 18'd0;
      rd_sh     <= 15'd0;
      mdio_in   <= 1'b0;
      reg_addr  <= 5'd0;
      reg_wdata <= 16'd0;
      reg_we    <= 1'b0;
      rd_done   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      mdc_q     <= mdc;
      state     <= state_next;
      cnt       <= cnt_next;
      hdr       <= hdr_next;
      wr_sh     <= wr_sh_next;
      rd_sh     <= rd_sh_next;
      mdio_in   <= mdio_in_next;
      reg_addr  <= reg_addr_next;
      reg_wdata <= reg_wdata_next;
      reg_we    <= reg_we_next;
      rd_done   <= rd_done_next;
      frame_err <= frame_err_next;
    end
  end

  // Frame decoding: cnt holds the number of the previous rise, so cnt==13
  // means this rise is rise 14 and cnt==31 means this rise is rise 32
  always_comb begin
    state_next     = state;
    cnt_next       = cnt;
    hdr_next       = hdr;
    wr_sh_next     = wr_sh;
    rd_sh_next     = rd_sh;
    mdio_in_next   = mdio_in;
    reg_addr_next  = reg_addr;
    reg_wdata_next = reg_wdata;
    reg_we_next    = 1'b0;
    rd_done_next   = 1'b0;
    frame_err_next = 1'b0;
    if (rise) begin
      cnt_next = cnt + 6'd1;
      case (state)
        IDLE: begin
          cnt_next = cnt;
          if (mdio_oe && !mdio_out) begin
            state_next = HEADER;
            cnt_next   = 6'd1;
            hdr_next   = {hdr[12:0], 1'b0};
          end
        end
        HEADER: begin
          hdr_next = {hdr[12:0], mdio_out};
          if (!mdio_oe) begin
            frame_err_next = 1'b1;
            state_next     = IDLE;
            cnt_next       = 6'd0;
          end else if (cnt == 6'd13) begin
            if (hdr_next[13:12] != 2'b01 ||
                (hdr_next[11:10] != 2'b01 && hdr_next[11:10] != 2'b10)) begin
              frame_err_next = 1'b1;
              state_next     = DRAIN;
            end else if (hdr_next[9:5] != PHY_ADDR) begin
              state_next = DRAIN;
            end else begin
              reg_addr_next = hdr_next[4:0];
              state_next    = (hdr_next[11:10] == 2'b01) ? WR : RD_TA;
            end
          end
        end
        WR: begin
          wr_sh_next = {wr_sh[16:0], mdio_out};
          if (cnt == 6'd31) begin
            state_next = IDLE;
            cnt_next   = 6'd0;
            if (wr_sh_next[17:16] == 2'b10) begin
              reg_wdata_next = wr_sh_next[15:0];
              reg_we_next    = 1'b1;
            end else begin
              frame_err_next = 1'b1;
            end
          end
        end
        RD_TA: begin
          if (cnt == 6'd14) begin
            mdio_in_next = 1'b0;
          end else begin
            rd_sh_next   = reg_rdata[14:0];
            mdio_in_next = reg_rdata[15];
            state_next   = RD_DATA;
          end
        end
        RD_DATA: begin
          if (cnt == 6'd31) begin
            mdio_in_next = 1'b0;
            rd_done_next = 1'b1;
            state_next   = IDLE;
            cnt_next     = 6'd0;
          end else begin
            mdio_in_next = rd_sh[14];
            rd_sh_next   = {rd_sh[13:0], 1'b0};
          end
        end
        DRAIN: begin
          if (cnt == 6'd31) begin
            state_next = IDLE;
            cnt_next   = 6'd0;
          end
        end
        default: begin
          state_next = IDLE;
          cnt_next   = 6'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdio_receiver.sv
// Bench for mdio_receiver: directed frames, a frame-level reference model
// compared every clk, plus hand-computed literal expectations.
module tb_mdio_receiver;

  localparam logic [4:0] TB_PHY = 5'd0;

  logic        clk = 1'b0;
  logic        reset;
  logic        mdc;
  logic        mdio_oe;
  logic        mdio_out;
  logic [15:0] reg_rdata;
  logic        mdio_in;
  logic [4:0]  reg_addr;
  logic [15:0] reg_wdata;
  logic        reg_we;
  logic        rd_done;
  logic        frame_err;
  logic        busy;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;
  int tb_rise = 0;
  int we_cnt = 0, err_cnt = 0, done_cnt = 0;
  int we_rise = 0, err_rise = 0, done_rise = 0;

  // reference model state
  logic        m_prev, m_active;
  int          m_k, m_mode;
  logic [31:0] m_word;
  logic [15:0] m_rd;
  logic [1:0]  m_st, m_op;
  logic        e_in, e_we, e_done, e_err, e_busy;
  logic [4:0]  e_addr;
  logic [15:0] e_wdata;

  logic [15:0] rb;
  logic        r15;

  always #5 clk = ~clk;

  mdio_receiver #(.PHY_ADDR(TB_PHY)) dut (
    .clk      (clk),
    .reset    (reset),
    .mdc      (mdc),
    .mdio_oe  (mdio_oe),
    .mdio_out (mdio_out),
    .reg_rdata(reg_rdata),
    .mdio_in  (mdio_in),
    .reg_addr (reg_addr),
    .reg_wdata(reg_wdata),
    .reg_we   (reg_we),
    .rd_done  (rd_done),
    .frame_err(frame_err),
    .busy     (busy)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: collects the 32 frame bits into a word and derives
  // the registered outputs from its fields at rises 14..32
  initial forever begin
    @(posedge clk or negedge reset);
    if (!reset) begin
      m_prev = 0; m_active = 0; m_k = 0; m_mode = 0; m_word = 0; m_rd = 0;
      e_in = 0; e_we = 0; e_done = 0; e_err = 0; e_busy = 0; e_addr = 0; e_wdata = 0;
    end else begin
      e_we = 0; e_done = 0; e_err = 0;
      if (mdc && !m_prev) begin
        if (!m_active) begin
          if (mdio_oe && !mdio_out) begin
            m_active = 1; m_k = 1; m_word = 0; m_mode = 0;
          end
        end else begin
          m_k = m_k + 1;
          m_word[32 - m_k] = mdio_out;
          if (m_mode == 0 && !mdio_oe) begin
            e_err = 1; m_active = 0;
          end else if (m_k == 14) begin
            m_st = m_word[31:30];
            m_op = m_word[29:28];
            if (m_st != 2'b01 || (m_op != 2'b01 && m_op != 2'b10)) begin
              e_err = 1; m_mode = 3;
            end else if (m_word[27:23] != TB_PHY) begin
              m_mode = 3;
            end else begin
              e_addr = m_word[22:18];
              m_mode = (m_op == 2'b01) ? 1 : 2;
            end
          end else if (m_mode == 2 && m_k == 15) begin
            e_in = 0;
          end else if (m_mode == 2 && m_k >= 16 && m_k <= 31) begin
            if (m_k == 16) m_rd = reg_rdata;
            e_in = m_rd[31 - m_k];
          end else if (m_k == 32) begin
            if (m_mode == 1) begin
              if (m_word[17:16] == 2'b10) begin
                e_we = 1; e_wdata = m_word[15:0];
              end else begin
                e_err = 1;
              end
            end else if (m_mode == 2) begin
              e_in = 0; e_done = 1;
            end
            m_active = 0;
          end
        end
      end
      m_prev = mdc;
      e_busy = m_active;
    end
  end

  // Compare DUT against the model every clk and tally observed strobes
  initial forever begin
    @(negedge clk);
    if (check_en) begin
      checkOutput("mdio_in",   32'(mdio_in),   32'(e_in));
      checkOutput("reg_we",    32'(reg_we),    32'(e_we));
      checkOutput("rd_done",   32'(rd_done),   32'(e_done));
      checkOutput("frame_err", 32'(frame_err), 32'(e_err));
      checkOutput("busy",      32'(busy),      32'(e_busy));
      checkOutput("reg_addr",  32'(reg_addr),  32'(e_addr));
      checkOutput("reg_wdata", 32'(reg_wdata), 32'(e_wdata));
    end
    if (reg_we === 1'b1)    begin we_cnt++;   we_rise = tb_rise;   end
    if (frame_err === 1'b1) begin err_cnt++;  err_rise = tb_rise;  end
    if (rd_done === 1'b1)   begin done_cnt++; done_rise = tb_rise; end
  end

  // One mdc period (2 clk high, 2 clk low); returns mdio_in as seen before the next rise
  task automatic mdc_bit(input logic oe, input logic d, input int rnum, output logic s);
    @(posedge clk);
    #1;
    mdio_oe  = oe;
    mdio_out = d;
    mdc      = 1'b1;
    tb_rise  = rnum;
    @(posedge clk);
    @(posedge clk);
    #1;
    s   = mdio_in;
    mdc = 1'b0;
    @(posedge clk);
  endtask

  task automatic applyStimulus(input logic [31:0] frame, input bit rd, input int pre,
                               input int abort_at, output logic [15:0] rbits, output logic rbit15);
    logic s, oe_b, d_b;
    for (int i = 0; i < pre; i++) mdc_bit(1'b1, 1'b1, 0, s);
    rbits  = 16'd0;
    rbit15 = 1'b1;
    for (int i = 0; i < 32; i++) begin
      oe_b = (rd && i >= 14) ? 1'b0 : 1'b1;
      d_b  = (rd && i >= 14) ? 1'b0 : frame[31 - i];
      mdc_bit(oe_b, d_b, i + 1, s);
      if (i == 14) rbit15 = s;
      if (i >= 15 && i <= 30) rbits = {rbits[14:0], s};
      if (i + 1 == abort_at) begin
        #2 reset = 1'b0;
        #1;
        checkOutput("rst_busy",      32'(busy),      32'd0);
        checkOutput("rst_reg_wdata", 32'(reg_wdata), 32'd0);
        checkOutput("rst_reg_addr",  32'(reg_addr),  32'd0);
        checkOutput("rst_strobes",   32'({reg_we, rd_done, frame_err, mdio_in}), 32'd0);
        repeat (3) @(posedge clk);
        #3 reset = 1'b1;
        tb_rise = 0;
        return;
      end
    end
    tb_rise = 0;
  endtask

  initial begin
    reset = 1'b0; mdc = 1'b0; mdio_oe = 1'b0; mdio_out = 1'b0; reg_rdata = 16'd0;
    #12;
    checkOutput("init_busy",    32'(busy),     32'd0);
    checkOutput("init_outputs", 32'({mdio_in, reg_we, rd_done, frame_err}), 32'd0);
    check_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // write frame to register 3
    applyStimulus(32'h500EBEEF, 1'b0, 0, 0, rb, r15);
    repeat (3) @(posedge clk);
    checkOutput("c1_we_count", 32'(we_cnt), 32'd1);
    checkOutput("c1_we_rise",  32'(we_rise), 32'd32);
    checkOutput("c1_reg_addr", 32'(reg_addr), 32'd3);
    checkOutput("c1_wdata",    32'(reg_wdata), 32'hBEEF);
    checkOutput("c1_err_count", 32'(err_cnt), 32'd0);

    // read frame returning A5C3
    reg_rdata = 16'hA5C3;
    applyStimulus(32'h600E0000, 1'b1, 0, 0, rb, r15);
    repeat (3) @(posedge clk);
    checkOutput("c2_ta_bit",     32'(r15), 32'd0);
    checkOutput("c2_read_bits",  32'(rb), 32'hA5C3);
    checkOutput("c2_done_count", 32'(done_cnt), 32'd1);
    checkOutput("c2_done_rise",  32'(done_rise), 32'd32);
    checkOutput("c2_we_count",   32'(we_cnt), 32'd1);

    // PHY mismatch, then back-to-back write frame
    applyStimulus(32'h508E1234, 1'b0, 0, 0, rb, r15);
    checkOutput("c3_busy_low",  32'(busy), 32'd0);
    checkOutput("c3_we_count",  32'(we_cnt), 32'd1);
    checkOutput("c3_err_count", 32'(err_cnt), 32'd0);
    applyStimulus(32'h500EBEEF, 1'b0, 0, 0, rb, r15);
    repeat (3) @(posedge clk);
    checkOutput("c3_b2b_we_count", 32'(we_cnt), 32'd2);

    // bad turnaround
    applyStimulus(32'h500C1234, 1'b0, 0, 0, rb, r15);
    repeat (3) @(posedge clk);
    checkOutput("c4_err_count", 32'(err_cnt), 32'd1);
    checkOutput("c4_err_rise",  32'(err_rise), 32'd32);
    checkOutput("c4_we_count",  32'(we_cnt), 32'd2);
    checkOutput("c4_wdata",     32'(reg_wdata), 32'hBEEF);

    // long preamble then write; then illegal opcode
    applyStimulus(32'h500EBEEF, 1'b0, 32, 0, rb, r15);
    repeat (3) @(posedge clk);
    checkOutput("c5_we_count", 32'(we_cnt), 32'd3);
    checkOutput("c5_we_rise",  32'(we_rise), 32'd32);
    applyStimulus(32'h700E0000, 1'b0, 0, 0, rb, r15);
    repeat (3) @(posedge clk);
    checkOutput("c5_err_count", 32'(err_cnt), 32'd2);
    checkOutput("c5_err_rise",  32'(err_rise), 32'd14);
    checkOutput("c5_we_count2", 32'(we_cnt), 32'd3);

    // reset mid-frame, then a fresh write
    applyStimulus(32'h500EBEEF, 1'b0, 0, 20, rb, r15);
    repeat (3) @(posedge clk);
    checkOutput("c6_no_write", 32'(we_cnt), 32'd3);
    applyStimulus(32'h500EBEEF, 1'b0, 0, 0, rb, r15);
    repeat (3) @(posedge clk);
    checkOutput("c6_we_count", 32'(we_cnt), 32'd4);
    checkOutput("c6_wdata",    32'(reg_wdata), 32'hBEEF);
    checkOutput("c6_err_count", 32'(err_cnt), 32'd2);

    check_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
